// File: rtl/sdr_pkg.sv
// Shared definitions for the sample datapath: width modes, the justified sample
// payload handed to the bit accumulator, and the flush FSM encoding.
package sdr_pkg;

  localparam logic [1:0] MODE_NATIVE = 2'd0;
  localparam logic [1:0] MODE_8      = 2'd1;
  localparam logic [1:0] MODE_12     = 2'd2;
  localparam logic [1:0] MODE_16     = 2'd3;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WIDTH_W  = 5;
  localparam int unsigned BYTE_W   = 8;

  // Sample left-justified in SAMPLE_W bits (unused LSBs zero) plus its bit count
  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic [WIDTH_W-1:0]  width;
  } sample_t;

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_PENDING,
    FLUSH_PAD
  } flush_state_e;

  function automatic logic [WIDTH_W-1:0] width_for_mode(input logic [1:0] mode,
                                                        input int unsigned in_width);
    case (mode)
      MODE_8:  return WIDTH_W'(8);
      MODE_12: return WIDTH_W'(12);
      MODE_16: return WIDTH_W'(16);
      default: return WIDTH_W'(in_width);
    endcase
  endfunction

endpackage

// File: rtl/bit_accumulator.sv
// MSB-aligned bit accumulator: pops one byte per cycle when >= 8 bits are held,
// appends whole samples below the remaining bits, and pads out a partial byte.
module bit_accumulator
  import sdr_pkg::*;
#(
  parameter int unsigned ACC_BITS = 32
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             push_req,
  input  sample_t                          push,
  input  logic                             pad_req,
  output logic                             accept_c,
  output logic                             pad_c,
  output logic [$clog2(ACC_BITS+1)-1:0]    fill,
  output logic                             byte_valid,
  output logic [BYTE_W-1:0]                byte_data,
  output logic                             busy
);

  localparam int unsigned FILL_W = $clog2(ACC_BITS + 1);
  localparam int unsigned CMP_W  = FILL_W + 1;

  logic [ACC_BITS-1:0] acc, acc_next, acc_shift, append;
  logic [CMP_W-1:0]    fill_x, remain;
  logic [FILL_W-1:0]   fill_next;
  logic                emit_c;

  // Bits below fill are always zero, so a pad pop is simply the top byte
  always_comb begin
    fill_x    = CMP_W'(fill);
    emit_c    = fill_x >= CMP_W'(BYTE_W);
    remain    = emit_c ? fill_x - CMP_W'(BYTE_W) : fill_x;
    accept_c  = push_req && ((remain + CMP_W'(push.width)) <= CMP_W'(ACC_BITS));
    pad_c     = pad_req && !emit_c && !accept_c && (fill != '0);
    acc_shift = emit_c ? (acc << BYTE_W) : acc;
    append    = (ACC_BITS'(push.data) << (ACC_BITS - SAMPLE_W)) >> remain;
    acc_next  = acc_shift | (accept_c ? append : '0);
    fill_next = FILL_W'(remain + (accept_c ? CMP_W'(push.width) : '0));
    if (pad_c) begin
      acc_next  = '0;
      fill_next = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc        <= '0;
      fill       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      busy       <= 1'b0;
    end else begin
      acc        <= acc_next;
      fill       <= fill_next;
      byte_valid <= emit_c || pad_c;
      if (emit_c || pad_c) begin
        byte_data <= acc[ACC_BITS-1 -: BYTE_W];
      end
      busy       <= fill_next != '0;
    end
  end

endmodule

// File: rtl/sample_packer.sv
// Packs IN_WIDTH-bit ADC samples into an MSB-first byte stream with a runtime
// width mode, partial-byte flush and sticky overflow on dropped samples.
module sample_packer
  import sdr_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned ACC_BITS = 32
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic [1:0]          mode,
  input  logic                flush,
  input  logic                ovf_clear,
  output logic                out_valid,
  output logic [BYTE_W-1:0]   out_data,
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned FILL_W = $clog2(ACC_BITS + 1);

  logic [1:0]          mode_q;
  flush_state_e        state_q, state_next;
  sample_t             sample_c;
  logic [SAMPLE_W-1:0] left_just_c, mask_c;
  logic [FILL_W-1:0]   fill;
  logic                accept_c, pad_c, pad_req_c;

  // Justify the raw sample to 16 bits, then keep only the mode's top bits
  always_comb begin
    left_just_c = SAMPLE_W'(in_data) << (SAMPLE_W - IN_WIDTH);
    case (mode_q)
      MODE_8:  mask_c = 16'hFF00;
      MODE_12: mask_c = 16'hFFF0;
      default: mask_c = 16'hFFFF;
    endcase
    sample_c.data  = left_just_c & mask_c;
    sample_c.width = width_for_mode(mode_q, IN_WIDTH);
  end

  bit_accumulator #(
    .ACC_BITS (ACC_BITS)
  ) u_acc (
    .clk        (clk),
    .nreset     (nreset),
    .push_req   (in_valid),
    .push       (sample_c),
    .pad_req    (pad_req_c),
    .accept_c   (accept_c),
    .pad_c      (pad_c),
    .fill       (fill),
    .byte_valid (out_valid),
    .byte_data  (out_data),
    .busy       (busy)
  );

  // Mode only changes on an empty, idle accumulator so a stream never mixes widths
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mode_q   <= MODE_NATIVE;
      overflow <= 1'b0;
      state_q  <= FLUSH_IDLE;
    end else begin
      if ((fill == '0) && !in_valid) begin
        mode_q <= mode;
      end
      if (in_valid && !accept_c) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
      state_q <= state_next;
    end
  end

  // Flush request toward the accumulator; kept apart from the next-state logic
  always_comb begin
    pad_req_c = 1'b0;
    case (state_q)
      FLUSH_PENDING: pad_req_c = 1'b1;
      default:       pad_req_c = flush && (fill != '0);
    endcase
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      FLUSH_PENDING: begin
        if (pad_c) begin
          state_next = FLUSH_PAD;
        end else if (fill == '0) begin
          state_next = FLUSH_IDLE;
        end
      end
      default: begin
        if (pad_req_c) begin
          state_next = pad_c ? FLUSH_PAD : FLUSH_PENDING;
        end else begin
          state_next = FLUSH_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: a 14-bit and a 12-bit instance, byte streams
// collected by a monitor and compared against hand-computed bytes.
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  mode;
  logic        flush, ovf_clear;
  logic        v14, v12;
  logic [13:0] d14;
  logic [11:0] d12;
  logic        ov14, ov12, of14, of12, b14, b12;
  logic [7:0]  od14, od12;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q14[$];
  logic [7:0] q12[$];

  always #5 clk = ~clk;

  sample_packer #(.IN_WIDTH(14), .ACC_BITS(32)) u_dut14 (
    .clk(clk), .nreset(nreset), .in_valid(v14), .in_data(d14), .mode(mode),
    .flush(flush), .ovf_clear(ovf_clear), .out_valid(ov14), .out_data(od14),
    .overflow(of14), .busy(b14)
  );

  sample_packer #(.IN_WIDTH(12), .ACC_BITS(32)) u_dut12 (
    .clk(clk), .nreset(nreset), .in_valid(v12), .in_data(d12), .mode(mode),
    .flush(flush), .ovf_clear(ovf_clear), .out_valid(ov12), .out_data(od12),
    .overflow(of12), .busy(b12)
  );

  always @(negedge clk) begin
    if (ov14) q14.push_back(od14);
    if (ov12) q12.push_back(od12);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // exp holds n bytes, first byte in the most significant used position
  task automatic expect_bytes(input string tag, input bit use12,
                              input logic [127:0] exp, input int n);
    int guard;
    int sz;
    logic [31:0] got;
    guard = 0;
    sz = use12 ? q12.size() : q14.size();
    while (sz < n && guard < 64) begin
      tick();
      guard++;
      sz = use12 ? q12.size() : q14.size();
    end
    tick(3);
    sz = use12 ? q12.size() : q14.size();
    check_eq($sformatf("%s count", tag), 32'(sz), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = 32'hFFFF_FFFF;
      if (i < sz) got = use12 ? 32'(q12[i]) : 32'(q14[i]);
      check_eq($sformatf("%s byte%0d", tag, i), got, 32'(exp[8*(n-1-i) +: 8]));
    end
    q12.delete();
    q14.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] smp [10];
    bit          bits[$];
    logic [9:0]  acc_mask;
    logic [7:0]  eb;
    int          guard;

    nreset = 1'b0; mode = 2'd2; flush = 1'b0; ovf_clear = 1'b0;
    v14 = 1'b0; v12 = 1'b0; d14 = '0; d12 = '0;
    tick(2);
    check_eq("rst out_valid", 32'(ov14), 32'd0);
    check_eq("rst out_data",  32'(od14), 32'd0);
    check_eq("rst overflow",  32'(of14), 32'd0);
    check_eq("rst busy",      32'(b14),  32'd0);
    check_eq("rst12 out_valid", 32'(ov12 | of12 | b12), 32'd0);
    nreset = 1'b1;
    tick(2);

    // 12-bit instance, mode 12: ABC, 123 -> AB C1 23
    d12 = 12'hABC; v12 = 1'b1; tick(); v12 = 1'b0;
    tick(2);
    d12 = 12'h123; v12 = 1'b1; tick(); v12 = 1'b0;
    expect_bytes("m12 stream", 1'b1, 128'hABC123, 3);
    check_eq("m12 busy idle", 32'(b12), 32'd0);

    // mode 8: 3FFF -> FF exactly one cycle after acceptance
    mode = 2'd1; tick();
    d14 = 14'h3FFF; v14 = 1'b1; tick(); v14 = 1'b0;
    check_eq("m8 no early byte", 32'(ov14), 32'd0);
    check_eq("m8 busy", 32'(b14), 32'd1);
    tick();
    check_eq("m8 valid N+1", 32'(ov14), 32'd1);
    check_eq("m8 data N+1", 32'(od14), 32'hFF);
    check_eq("m8 empty", 32'(b14), 32'd0);
    tick();
    q14.delete();

    // native 14 bits, continuous: samples 4, 6, 8 do not fit and are dropped
    mode = 2'd0; tick();
    for (int i = 0; i < 10; i++) smp[i] = 14'(i * 1237 + 421);
    acc_mask = 10'b10_1010_1111;
    for (int i = 0; i < 10; i++) begin
      d14 = smp[i]; v14 = 1'b1; tick();
      if (i == 3) check_eq("native ovf before", 32'(of14), 32'd0);
      if (i == 4) check_eq("native ovf set", 32'(of14), 32'd1);
    end
    v14 = 1'b0;
    tick(5);
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 10; i++)
      if (acc_mask[i])
        for (int b = 13; b >= 0; b--) bits.push_back(smp[i][b]);
    while (bits.size() % 8 != 0) bits.push_back(1'b0);
    guard = 0;
    while (q14.size() < bits.size() / 8 && guard < 64) begin tick(); guard++; end
    tick(3);
    check_eq("native count", 32'(q14.size()), 32'(bits.size() / 8));
    for (int k = 0; k < bits.size() / 8; k++) begin
      for (int b = 0; b < 8; b++) eb[7-b] = bits[8*k + b];
      check_eq($sformatf("native byte%0d", k), (k < q14.size()) ? 32'(q14[k]) : 32'hFFFF_FFFF, 32'(eb));
    end
    q14.delete();
    check_eq("native busy", 32'(b14), 32'd0);

    // mode 12 on 14-bit input (2AF3 -> ABC), flush while a byte is still due
    mode = 2'd2; tick();
    d14 = 14'h2AF3; v14 = 1'b1; tick(); v14 = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    expect_bytes("flush pend", 1'b0, 128'hABC0, 2);
    check_eq("flush busy", 32'(b14), 32'd0);

    // mode input moves 1 -> 3 with 4 bits held; takes effect only after the flush
    d14 = 14'h2AF3; v14 = 1'b1; tick(); v14 = 1'b0;
    tick();
    mode = 2'd1; tick();
    mode = 2'd3; tick(2);
    check_eq("modechg busy", 32'(b14), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    expect_bytes("modechg flush", 1'b0, 128'hABC0, 2);
    d14 = 14'h2001; v14 = 1'b1; tick(); v14 = 1'b0;
    expect_bytes("m16 2001", 1'b0, 128'h8004, 2);

    // reset with 20 bits held (overflow still set from the native run)
    mode = 2'd0; tick();
    d14 = 14'h1555; v14 = 1'b1; tick();
    d14 = 14'h2AAA; tick(); v14 = 1'b0;
    check_eq("prerst valid", 32'(ov14), 32'd1);
    nreset = 1'b0; #1;
    check_eq("midrst valid", 32'(ov14), 32'd0);
    check_eq("midrst overflow", 32'(of14), 32'd0);
    check_eq("midrst busy", 32'(b14), 32'd0);
    tick(2);
    @(negedge clk); nreset = 1'b1;
    tick(2);
    check_eq("postrst valid", 32'(ov14), 32'd0);
    q14.delete();
    d14 = 14'h2001; v14 = 1'b1; tick(); v14 = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    expect_bytes("postrst stream", 1'b0, 128'h8004, 2);

    // mode 16: fourth sample dropped while ovf_clear is high; set must win
    mode = 2'd3; tick();
    d14 = 14'h2AF3; v14 = 1'b1; tick();
    d14 = 14'h0001; tick();
    d14 = 14'h3FFF; tick();
    d14 = 14'h1111; ovf_clear = 1'b1; tick();
    check_eq("ovf set beats clear", 32'(of14), 32'd1);
    v14 = 1'b0; tick();
    check_eq("ovf cleared", 32'(of14), 32'd0);
    ovf_clear = 1'b0;
    expect_bytes("m16 stream", 1'b0, 128'hABCC0004FFFC, 6);
    check_eq("m16 busy", 32'(b14), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
